// File: rtl/uart_burst_bridge_master_if.sv
// Handshake bundle between the UART burst bridge and its surroundings: UART RX command side,
// serial-bus master side and UART TX response side.
interface uart_burst_bridge_master_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int BB_ADDR_WIDTH = 14,
  parameter int LEN_WIDTH     = 4,
  parameter int CMD_DEPTH     = 8
) ();
  localparam int CMD_W = 1 + LEN_WIDTH + DATA_WIDTH + BB_ADDR_WIDTH;
  localparam int RSP_W = DATA_WIDTH + 8;
  localparam int LVL_W = $clog2(CMD_DEPTH) + 1;

  logic                  cmd_valid;
  logic [CMD_W-1:0]      cmd_data;
  logic                  cmd_ready;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_mode;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  rsp_valid;
  logic [RSP_W-1:0]      rsp_data;
  logic                  rsp_ready;
  logic [LVL_W-1:0]      cmd_level;
  logic                  ovf_err;

  modport master (
    input  cmd_valid, cmd_data, m_ready, m_rdata, rsp_ready,
    output cmd_ready, m_valid, m_mode, m_addr, m_wdata, rsp_valid, rsp_data, cmd_level, ovf_err
  );

  modport slave (
    output cmd_valid, cmd_data, m_ready, m_rdata, rsp_ready,
    input  cmd_ready, m_valid, m_mode, m_addr, m_wdata, rsp_valid, rsp_data, cmd_level, ovf_err
  );
endinterface

// File: rtl/uart_burst_bridge_master.sv
// UART command engine: queues burst commands, expands them into single-beat bus transactions and
// returns read data through a response FIFO. Define BRIDGE_WR_ACK_EN to also acknowledge each write beat.
module uart_burst_bridge_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int BB_ADDR_WIDTH = 14,
  parameter int LEN_WIDTH     = 4,
  parameter int CMD_DEPTH     = 8,
  parameter int RSP_DEPTH     = 4
) (
  input  logic clk,
  input  logic rstn,
  uart_burst_bridge_master_if.master bus
);
  localparam int CMD_W  = 1 + LEN_WIDTH + DATA_WIDTH + BB_ADDR_WIDTH;
  localparam int RSP_W  = DATA_WIDTH + 8;
  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int CMD_LW = CMD_AW + 1;
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int RSP_LW = RSP_AW + 1;
`ifdef BRIDGE_WR_ACK_EN
  localparam logic WR_ACK_EN = 1'b1;
`else
  localparam logic WR_ACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE} state_t;

  function automatic logic [6:0] idx7(input logic [LEN_WIDTH-1:0] idx);
    return 7'(idx);
  endfunction

  logic [CMD_W-1:0]         cmd_mem_r [CMD_DEPTH];
  logic [CMD_AW-1:0]        cmd_wr_ptr_r, cmd_rd_ptr_r;
  logic [CMD_LW-1:0]        cmd_level_r;
  logic                     ovf_r;
  logic [RSP_W-1:0]         rsp_mem_r [RSP_DEPTH];
  logic [RSP_AW-1:0]        rsp_wr_ptr_r, rsp_rd_ptr_r;
  logic [RSP_LW-1:0]        rsp_level_r;

  state_t                   state_r;
  logic                     mode_r;
  logic [LEN_WIDTH-1:0]     beat_cnt_r, beat_idx_r;
  logic [BB_ADDR_WIDTH-1:0] cur_addr_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic                     m_valid_r, m_mode_r;
  logic [ADDR_WIDTH-1:0]    m_addr_r;
  logic [DATA_WIDTH-1:0]    m_wdata_r;

  logic                     cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;
  logic [CMD_W-1:0]         cmd_head_s;
  logic                     rsp_full_s, rsp_empty_s, rsp_push_s, rsp_pop_s;
  logic [RSP_W-1:0]         rsp_wdata_s;
  logic                     done_s, issue_ok_s;

  assign cmd_full_s  = (cmd_level_r == CMD_LW'(CMD_DEPTH));
  assign cmd_empty_s = (cmd_level_r == {CMD_LW{1'b0}});
  assign cmd_push_s  = bus.cmd_valid && !cmd_full_s;
  assign cmd_pop_s   = (state_r == ST_IDLE) && !cmd_empty_s;
  assign cmd_head_s  = cmd_mem_r[cmd_rd_ptr_r];

  // A beat completes on the first m_ready high seen after the bus went busy.
  assign done_s      = (state_r == ST_WAIT_DONE) && bus.m_ready;
  assign rsp_full_s  = (rsp_level_r == RSP_LW'(RSP_DEPTH));
  assign rsp_empty_s = (rsp_level_r == {RSP_LW{1'b0}});
  assign rsp_push_s  = done_s && (!mode_r || WR_ACK_EN);
  assign rsp_pop_s   = !rsp_empty_s && bus.rsp_ready;
  assign rsp_wdata_s = {mode_r, idx7(beat_idx_r), (mode_r ? wdata_r : bus.m_rdata)};
  // Reserving response space before issuing is what makes rsp FIFO overflow impossible.
  assign issue_ok_s  = bus.m_ready && (!rsp_full_s || (mode_r && !WR_ACK_EN));

  assign bus.cmd_ready = !cmd_full_s;
  assign bus.cmd_level = cmd_level_r;
  assign bus.ovf_err   = ovf_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_mode    = m_mode_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.rsp_valid = !rsp_empty_s;
  assign bus.rsp_data  = rsp_empty_s ? {RSP_W{1'b0}} : rsp_mem_r[rsp_rd_ptr_r];

  // Command FIFO storage.
  always_ff @(posedge clk) begin
    if (cmd_push_s) cmd_mem_r[cmd_wr_ptr_r] <= bus.cmd_data;
  end

  // Command FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_wr_ptr_r <= {CMD_AW{1'b0}};
      cmd_rd_ptr_r <= {CMD_AW{1'b0}};
      cmd_level_r  <= {CMD_LW{1'b0}};
      ovf_r        <= 1'b0;
    end else begin
      if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + CMD_AW'(1'b1);
      if (cmd_pop_s)  cmd_rd_ptr_r <= cmd_rd_ptr_r + CMD_AW'(1'b1);
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_level_r <= cmd_level_r + CMD_LW'(1'b1);
        2'b01:   cmd_level_r <= cmd_level_r - CMD_LW'(1'b1);
        default: cmd_level_r <= cmd_level_r;
      endcase
      if (bus.cmd_valid && cmd_full_s) ovf_r <= 1'b1;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (rsp_push_s) rsp_mem_r[rsp_wr_ptr_r] <= rsp_wdata_s;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_wr_ptr_r <= {RSP_AW{1'b0}};
      rsp_rd_ptr_r <= {RSP_AW{1'b0}};
      rsp_level_r  <= {RSP_LW{1'b0}};
    end else begin
      if (rsp_push_s) rsp_wr_ptr_r <= rsp_wr_ptr_r + RSP_AW'(1'b1);
      if (rsp_pop_s)  rsp_rd_ptr_r <= rsp_rd_ptr_r + RSP_AW'(1'b1);
      case ({rsp_push_s, rsp_pop_s})
        2'b10:   rsp_level_r <= rsp_level_r + RSP_LW'(1'b1);
        2'b01:   rsp_level_r <= rsp_level_r - RSP_LW'(1'b1);
        default: rsp_level_r <= rsp_level_r;
      endcase
    end
  end

  // Burst sequencer with registered bus request outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      mode_r     <= 1'b0;
      beat_cnt_r <= {LEN_WIDTH{1'b0}};
      beat_idx_r <= {LEN_WIDTH{1'b0}};
      cur_addr_r <= {BB_ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      m_valid_r  <= 1'b0;
      m_mode_r   <= 1'b0;
      m_addr_r   <= {ADDR_WIDTH{1'b0}};
      m_wdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      m_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!cmd_empty_s) begin
            mode_r     <= cmd_head_s[CMD_W-1];
            beat_cnt_r <= cmd_head_s[BB_ADDR_WIDTH+DATA_WIDTH +: LEN_WIDTH];
            beat_idx_r <= {LEN_WIDTH{1'b0}};
            wdata_r    <= cmd_head_s[BB_ADDR_WIDTH +: DATA_WIDTH];
            cur_addr_r <= cmd_head_s[BB_ADDR_WIDTH-1:0];
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_ok_s) begin
            m_valid_r <= 1'b1;
            m_mode_r  <= mode_r;
            m_addr_r  <= ADDR_WIDTH'(cur_addr_r);
            m_wdata_r <= wdata_r;
            state_r   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!bus.m_ready) state_r <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.m_ready) begin
            if (beat_cnt_r == {LEN_WIDTH{1'b0}}) begin
              state_r <= ST_IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r - LEN_WIDTH'(1'b1);
              beat_idx_r <= beat_idx_r + LEN_WIDTH'(1'b1);
              cur_addr_r <= cur_addr_r + BB_ADDR_WIDTH'(1'b1);
              state_r    <= ST_ISSUE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_burst_bridge_master.sv
// Self-checking bench for uart_burst_bridge_master: directed and random bursts against a
// transaction-level reference (expected bus requests and responses per command).
module tb_uart_burst_bridge_master;
  localparam int AW = 16, DW = 8, BBW = 14, LW = 4, CD = 8, RD = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_burst_bridge_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BB_ADDR_WIDTH(BBW),
                                .LEN_WIDTH(LW), .CMD_DEPTH(CD)) bus_if ();

  uart_burst_bridge_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BB_ADDR_WIDTH(BBW),
                             .LEN_WIDTH(LW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .clk(clk), .rstn(rstn), .bus(bus_if));

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  logic [7:0]  bus_mem [65536];
  logic [7:0]  ref_mem [65536];
  logic [24:0] req_q[$], exp_req_q[$];   // {mode, addr, wdata (0 for reads)}
  logic [15:0] rsp_q[$], exp_rsp_q[$];
  bit bus_hold = 1'b0, rsp_rand = 1'b0, rsp_force = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a burst touches len+1 consecutive addresses modulo 2^14, in order.
  task automatic model_cmd(input bit mode, input int len, input logic [7:0] wd, input logic [13:0] a);
    for (int i = 0; i <= len; i++) begin
      logic [13:0] ai;
      ai = a + 14'(i);
      exp_req_q.push_back({mode, 16'(ai), (mode ? wd : 8'h00)});
      if (mode) begin
        ref_mem[16'(ai)] = wd;
`ifdef BRIDGE_WR_ACK_EN
        exp_rsp_q.push_back({1'b1, 7'(i), wd});
`endif
      end else begin
        exp_rsp_q.push_back({1'b0, 7'(i), ref_mem[16'(ai)]});
      end
    end
  endtask

  task automatic push_cmd(input bit mode, input int len, input logic [7:0] wd, input logic [13:0] a);
    int guard = 0;
    while (!bus_if.cmd_ready && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 500) check("cmd_ready_timeout", 32'd0, 32'd1);
    bus_if.cmd_data  = {mode, 4'(len), wd, a};
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    model_cmd(mode, len, wd, a);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while ((req_q.size() < exp_req_q.size() || rsp_q.size() < exp_rsp_q.size()) && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 20000), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_nreq"}, req_q.size(), exp_req_q.size());
    check({tag, "_nrsp"}, rsp_q.size(), exp_rsp_q.size());
    for (int i = 0; i < req_q.size() && i < exp_req_q.size(); i++)
      check($sformatf("%s_req%0d", tag, i), 32'(req_q[i]), 32'(exp_req_q[i]));
    for (int i = 0; i < rsp_q.size() && i < exp_rsp_q.size(); i++)
      check($sformatf("%s_rsp%0d", tag, i), 32'(rsp_q[i]), 32'(exp_rsp_q[i]));
  endtask

  task automatic clear_q();
    req_q.delete(); exp_req_q.delete(); rsp_q.delete(); exp_rsp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_valid"},   32'(bus_if.m_valid),   32'd0);
    check({tag, "_m_mode"},    32'(bus_if.m_mode),    32'd0);
    check({tag, "_m_addr"},    32'(bus_if.m_addr),    32'd0);
    check({tag, "_m_wdata"},   32'(bus_if.m_wdata),   32'd0);
    check({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(bus_if.rsp_data),  32'd0);
    check({tag, "_cmd_level"}, 32'(bus_if.cmd_level), 32'd0);
    check({tag, "_ovf_err"},   32'(bus_if.ovf_err),   32'd0);
    check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
  endtask

  // Serial-bus slave model: busy for 1..3 cycles per request, read data from bus_mem.
  initial begin
    bus_if.m_ready = 1'b1;
    bus_if.m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rstn && bus_if.m_valid) begin
        req_q.push_back({bus_if.m_mode, bus_if.m_addr, (bus_if.m_mode ? bus_if.m_wdata : 8'h00)});
        bus_if.m_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (bus_if.m_mode) bus_mem[bus_if.m_addr] = bus_if.m_wdata;
        else bus_if.m_rdata = bus_mem[bus_if.m_addr];
        bus_if.m_ready = 1'b1;
      end else begin
        bus_if.m_ready = !bus_hold;
      end
    end
  end

  // UART TX side: ready either forced or random.
  initial begin
    bus_if.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus_if.rsp_ready = rsp_rand ? ($urandom_range(0, 1) == 1) : rsp_force;
    end
  end

  always @(negedge clk) begin
    if (rstn && bus_if.rsp_valid && bus_if.rsp_ready) rsp_q.push_back(bus_if.rsp_data);
  end

  initial begin
    logic [15:0] wrap_addr [4];
    int accepted, guard;
    wrap_addr = '{16'h3FFE, 16'h3FFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[16'h0040] = 8'h3C;
    ref_mem[16'h0040] = 8'h3C;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_data  = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single write: three-cycle latency and a one-cycle request pulse.
    push_cmd(1'b1, 0, 8'hA5, 14'h0123);
    check("wr_lat_e1", 32'(bus_if.m_valid), 32'd0);
    @(posedge clk); #1;
    check("wr_lat_e2", 32'(bus_if.m_valid), 32'd0);
    @(posedge clk); #1;
    check("wr_lat_e3", 32'(bus_if.m_valid), 32'd1);
    check("wr_m_addr", 32'(bus_if.m_addr), 32'h0123);
    check("wr_m_wdata", 32'(bus_if.m_wdata), 32'hA5);
    check("wr_m_mode", 32'(bus_if.m_mode), 32'd1);
    @(posedge clk); #1;
    check("wr_pulse", 32'(bus_if.m_valid), 32'd0);
    wait_done("wr1");
    clear_q();

    // Single read held in the response FIFO until TX is ready.
    rsp_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_cmd(1'b0, 0, 8'h00, 14'h0040);
    guard = 0;
    while (req_q.size() < 1 && guard < 200) begin @(posedge clk); #1; guard++; end
    repeat (6) @(posedge clk);
    #1;
    check("rd1_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("rd1_rsp_data", 32'(bus_if.rsp_data), 32'h003C);
    repeat (3) @(posedge clk);
    #1;
    check("rd1_rsp_hold", 32'(bus_if.rsp_valid), 32'd1);
    rsp_force = 1'b1;
    wait_done("rd1");
    clear_q();

    // Burst read across the 14-bit address wrap.
    push_cmd(1'b0, 3, 8'h00, 14'h3FFE);
    wait_done("wrap");
    for (int i = 0; i < 4 && i < req_q.size(); i++)
      check($sformatf("wrap_addr%0d", i), 32'(req_q[i][23:8]), 32'(wrap_addr[i]));
    clear_q();

`ifdef BRIDGE_WR_ACK_EN
    push_cmd(1'b1, 1, 8'h5A, 14'h0200);
    wait_done("ack");
    if (rsp_q.size() >= 2) begin
      check("ack_rsp0", 32'(rsp_q[0]), 32'h805A);
      check("ack_rsp1", 32'(rsp_q[1]), 32'h815A);
    end
    clear_q();
`endif

    // Full response FIFO stalls issue after four reads.
    rsp_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_cmd(1'b0, 7, 8'h00, 14'($urandom));
    guard = 0;
    while (req_q.size() < 4 && guard < 500) begin @(posedge clk); #1; guard++; end
    repeat (20) @(posedge clk);
    #1;
    check("stall_nreq", req_q.size(), 32'd4);
    check("stall_m_valid", 32'(bus_if.m_valid), 32'd0);
    check("stall_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    rsp_force = 1'b1;
    wait_done("stall");
    clear_q();

    // Random command mix with random TX backpressure.
    rsp_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      bit          md;
      int          ln;
      logic [13:0] ad;
      md = 1'($urandom);
      ln = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      ad = ($urandom_range(0, 3) == 0) ? 14'(16'h3FFA + 16'($urandom_range(0, 5))) : 14'($urandom);
      push_cmd(md, ln, 8'($urandom), ad);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_done("rand");
    rsp_rand = 1'b0;
    clear_q();

    // Overflow with the bus held busy, then reset clears everything.
    bus_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    accepted = 0;
    for (int i = 0; i < 12 && bus_if.cmd_ready; i++) begin
      bus_if.cmd_data  = {1'b0, 4'd0, 8'h00, 14'(i)};
      bus_if.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus_if.cmd_valid = 1'b0;
      accepted++;
    end
    check("ovf_accepted", 32'(accepted), 32'd9);
    check("ovf_level", 32'(bus_if.cmd_level), 32'd8);
    check("ovf_ready", 32'(bus_if.cmd_ready), 32'd0);
    check("ovf_err_pre", 32'(bus_if.ovf_err), 32'd0);
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    check("ovf_err_set", 32'(bus_if.ovf_err), 32'd1);
    check("ovf_level_kept", 32'(bus_if.cmd_level), 32'd8);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_err_sticky", 32'(bus_if.ovf_err), 32'd1);
    check("ovf_no_req", req_q.size(), 32'd0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check_reset("rst2");
    bus_hold = 1'b0;
    clear_q();

    // Bridge works normally again after the reset.
    push_cmd(1'b0, 1, 8'h00, 14'h1234);
    wait_done("post");
    clear_q();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
